// File: rtl/mem_arbiter_if.sv
// Requester-side memory port: request fields with a same-cycle grant, then a
// one-cycle completion pulse carrying error flag and read data.
interface mem_arbiter_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, err, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, err, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for instr/data onto one downstream port, one transaction outstanding;
// grant is combinational in IDLE, completion pulse one cycle after response or timeout.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave instr_if,
  mem_arbiter_if.slave data_if,
  output logic         mem_req_o,
  output logic [31:0]  mem_addr_o,
  output logic         mem_we_o,
  output logic [3:0]   mem_be_o,
  output logic [31:0]  mem_wdata_o,
  input  logic         mem_rvalid_i,
  input  logic         mem_err_i,
  input  logic [31:0]  mem_rdata_i
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q;
  logic          last_q;   // 1: data was granted most recently
  logic          owner_q;  // 0: instr, 1: data
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [1:0]    rvalid_q;
  logic [1:0]    err_q;
  logic [31:0]   rdata_q [2];

  logic          sel_d;
  logic          gnt_any;
  logic          resp;
  logic          tmo;
  logic [31:0]   addr_d;
  logic          we_d;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;

  // On a tie, pick the requester that did not win last time.
  assign sel_d   = (instr_if.req && data_if.req) ? ~last_q : data_if.req;
  assign gnt_any = (state_q == IDLE) && (instr_if.req || data_if.req);

  assign instr_if.gnt = gnt_any && !sel_d;
  assign data_if.gnt  = gnt_any &&  sel_d;

  assign addr_d  = sel_d ? data_if.addr  : instr_if.addr;
  assign we_d    = sel_d ? data_if.we    : instr_if.we;
  assign be_d    = sel_d ? data_if.be    : instr_if.be;
  assign wdata_d = sel_d ? data_if.wdata : instr_if.wdata;

  assign resp = mem_rvalid_i || mem_err_i;
  assign tmo  = (cnt_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      rvalid_q   <= '0;
      err_q      <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      rvalid_q   <= '0;
      err_q      <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            state_q <= BUSY;
            owner_q <= sel_d;
            last_q  <= sel_d;
            cnt_q   <= '0;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
          end
        end
        BUSY: begin
          if (resp || tmo) begin
            // Captured fields are cleared so the downstream bus reads 0 while idle.
            state_q           <= IDLE;
            cnt_q             <= '0;
            addr_q            <= '0;
            we_q              <= 1'b0;
            be_q              <= '0;
            wdata_q           <= '0;
            rvalid_q[owner_q] <= 1'b1;
            err_q[owner_q]    <= resp ? mem_err_i : 1'b1;
            rdata_q[owner_q]  <= resp ? mem_rdata_i : 32'h0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_o   = (state_q == BUSY);
  assign mem_addr_o  = addr_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

  assign instr_if.rvalid = rvalid_q[0];
  assign instr_if.err    = err_q[0];
  assign instr_if.rdata  = rdata_q[0];
  assign data_if.rvalid  = rvalid_q[1];
  assign data_if.err     = err_q[1];
  assign data_if.rdata   = rdata_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with an 8-cycle timeout.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i = 1'b0;
  logic        mem_err_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;

  int checks = 0;
  int failures = 0;

  mem_arbiter_if instr_if ();
  mem_arbiter_if data_if ();

  mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_if     (instr_if.slave),
    .data_if      (data_if.slave),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_err_i    (mem_err_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    instr_if.req = 1'b0; instr_if.addr = '0; instr_if.we = 1'b0; instr_if.be = '0; instr_if.wdata = '0;
    data_if.req = 1'b0; data_if.addr = '0; data_if.we = 1'b0; data_if.be = '0; data_if.wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_reqs();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%0h exp=0", mem_req_o); end
    checks++; if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== 69'h0) begin failures++; $display("FAIL rst_mem_fields got=%h exp=0", {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o}); end
    checks++; if ({instr_if.rvalid, instr_if.err, data_if.rvalid, data_if.err} !== 4'h0) begin failures++; $display("FAIL rst_resp got=%b exp=0000", {instr_if.rvalid, instr_if.err, data_if.rvalid, data_if.err}); end
    rst = 1'b1;
    tick();
  endtask

  // Single instr write, response three cycles after mem_req_o rises.
  task automatic test_single_write();
    instr_if.req = 1'b1; instr_if.addr = 32'h1000; instr_if.we = 1'b1; instr_if.be = 4'hF; instr_if.wdata = 32'hA5A5A5A5;
    #1;
    checks++; if ({instr_if.gnt, data_if.gnt} !== 2'b10) begin failures++; $display("FAIL wr_gnt got=%b exp=10", {instr_if.gnt, data_if.gnt}); end
    tick();
    clear_reqs();
    checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL wr_mem_req got=%0h exp=1", mem_req_o); end
    checks++; if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== {32'h1000, 1'b1, 4'hF, 32'hA5A5A5A5}) begin failures++; $display("FAIL wr_fields got=%h exp=%h", {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o}, {32'h1000, 1'b1, 4'hF, 32'hA5A5A5A5}); end
    tick();
    tick();
    tick();
    checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h1000}) begin failures++; $display("FAIL wr_hold got=%h exp=%h", {mem_req_o, mem_addr_o}, {1'b1, 32'h1000}); end
    mem_rvalid_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    checks++; if ({instr_if.rvalid, instr_if.err} !== 2'b10) begin failures++; $display("FAIL wr_done got=%b exp=10", {instr_if.rvalid, instr_if.err}); end
    checks++; if ({mem_req_o, mem_addr_o, mem_wdata_o} !== 65'h0) begin failures++; $display("FAIL wr_idle_bus got=%h exp=0", {mem_req_o, mem_addr_o, mem_wdata_o}); end
    tick();
    checks++; if (instr_if.rvalid !== 1'b0) begin failures++; $display("FAIL wr_pulse_len got=%0h exp=0", instr_if.rvalid); end
  endtask

  // Both requesting continuously after reset: instr, data, instr, data.
  task automatic test_round_robin();
    logic        exp_d;
    logic [31:0] exp_addr;
    do_reset();
    instr_if.req = 1'b1; instr_if.addr = 32'h2000;
    data_if.req  = 1'b1; data_if.addr  = 32'h3000;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_d    = (i % 2) == 1;
      exp_addr = exp_d ? 32'h3000 : 32'h2000;
      checks++; if ({instr_if.gnt, data_if.gnt} !== {!exp_d, exp_d}) begin failures++; $display("FAIL rr_gnt%0d got=%b exp=%b", i, {instr_if.gnt, data_if.gnt}, {!exp_d, exp_d}); end
      tick();
      checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, exp_addr}) begin failures++; $display("FAIL rr_bus%0d got=%h exp=%h", i, {mem_req_o, mem_addr_o}, {1'b1, exp_addr}); end
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h100 + i;
      tick();
      mem_rvalid_i = 1'b0;
      checks++; if ({instr_if.rvalid, data_if.rvalid, mem_req_o} !== {!exp_d, exp_d, 1'b0}) begin failures++; $display("FAIL rr_done%0d got=%b exp=%b", i, {instr_if.rvalid, data_if.rvalid, mem_req_o}, {!exp_d, exp_d, 1'b0}); end
      checks++; if ((exp_d ? data_if.rdata : instr_if.rdata) !== 32'h100 + i) begin failures++; $display("FAIL rr_rdata%0d got=%h exp=%h", i, exp_d ? data_if.rdata : instr_if.rdata, 32'h100 + i); end
    end
    clear_reqs();
    tick();
  endtask

  // Data read answered with an error; also both flags together, and a stray response in IDLE.
  task automatic test_error();
    data_if.req = 1'b1; data_if.addr = 32'h0050; data_if.we = 1'b0; data_if.be = 4'hF;
    #1;
    checks++; if ({instr_if.gnt, data_if.gnt} !== 2'b01) begin failures++; $display("FAIL err_gnt got=%b exp=01", {instr_if.gnt, data_if.gnt}); end
    tick();
    clear_reqs();
    checks++; if ({mem_req_o, mem_addr_o, mem_we_o} !== {1'b1, 32'h0050, 1'b0}) begin failures++; $display("FAIL err_bus got=%h exp=%h", {mem_req_o, mem_addr_o, mem_we_o}, {1'b1, 32'h0050, 1'b0}); end
    mem_err_i = 1'b1;
    tick();
    mem_err_i = 1'b0;
    checks++; if ({data_if.rvalid, data_if.err} !== 2'b11) begin failures++; $display("FAIL err_done got=%b exp=11", {data_if.rvalid, data_if.err}); end
    checks++; if ({instr_if.rvalid, instr_if.err, instr_if.rdata} !== 34'h0) begin failures++; $display("FAIL err_other got=%h exp=0", {instr_if.rvalid, instr_if.err, instr_if.rdata}); end
    data_if.req = 1'b1; data_if.addr = 32'h0060;
    tick();
    clear_reqs();
    mem_rvalid_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = 32'h0BAD0BAD;
    tick();
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    checks++; if ({data_if.rvalid, data_if.err, data_if.rdata} !== {2'b11, 32'h0BAD0BAD}) begin failures++; $display("FAIL both_flags got=%h exp=%h", {data_if.rvalid, data_if.err, data_if.rdata}, {2'b11, 32'h0BAD0BAD}); end
    tick();
    mem_rvalid_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    checks++; if ({instr_if.rvalid, data_if.rvalid, mem_req_o} !== 3'b000) begin failures++; $display("FAIL idle_resp got=%b exp=000", {instr_if.rvalid, data_if.rvalid, mem_req_o}); end
  endtask

  // No downstream response: eight BUSY cycles then a forced error completion.
  task automatic test_timeout();
    instr_if.req = 1'b1; instr_if.addr = 32'h4000;
    mem_rdata_i = 32'hDEADBEEF;
    tick();
    clear_reqs();
    for (int k = 0; k < 8; k++) begin
      checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL tmo_busy%0d got=%0h exp=1", k, mem_req_o); end
      tick();
    end
    checks++; if ({mem_req_o, instr_if.rvalid, instr_if.err, instr_if.rdata} !== {3'b011, 32'h0}) begin failures++; $display("FAIL tmo_done got=%h exp=%h", {mem_req_o, instr_if.rvalid, instr_if.err, instr_if.rdata}, {3'b011, 32'h0}); end
    mem_rdata_i = 32'h0;
    tick();
  endtask

  // Reset while BUSY: response after release must not reach a requester.
  task automatic test_reset_busy();
    instr_if.req = 1'b1; instr_if.addr = 32'h5000;
    tick();
    clear_reqs();
    rst = 1'b0;
    #1;
    checks++; if ({mem_req_o, mem_addr_o} !== 33'h0) begin failures++; $display("FAIL rstb_async got=%h exp=0", {mem_req_o, mem_addr_o}); end
    tick();
    rst = 1'b1;
    tick();
    mem_rvalid_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    checks++; if ({instr_if.rvalid, data_if.rvalid, mem_req_o} !== 3'b000) begin failures++; $display("FAIL rstb_no_resp got=%b exp=000", {instr_if.rvalid, data_if.rvalid, mem_req_o}); end
    data_if.req = 1'b1; data_if.addr = 32'h6000;
    #1;
    checks++; if (data_if.gnt !== 1'b1) begin failures++; $display("FAIL rstb_regrant got=%0h exp=1", data_if.gnt); end
    tick();
    clear_reqs();
    checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h6000}) begin failures++; $display("FAIL rstb_bus got=%h exp=%h", {mem_req_o, mem_addr_o}, {1'b1, 32'h6000}); end
    mem_rvalid_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    tick();
  endtask

  // Read returning data while the other requester waits; waiter granted in the pulse cycle.
  task automatic test_back_to_back();
    data_if.req = 1'b1; data_if.addr = 32'h1004; data_if.we = 1'b0;
    tick();
    clear_reqs();
    instr_if.req = 1'b1; instr_if.addr = 32'h7000;
    #1;
    checks++; if (instr_if.gnt !== 1'b0) begin failures++; $display("FAIL b2b_busy_gnt got=%0h exp=0", instr_if.gnt); end
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h12345678;
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    checks++; if ({data_if.rvalid, data_if.rdata} !== {1'b1, 32'h12345678}) begin failures++; $display("FAIL b2b_rdata got=%h exp=%h", {data_if.rvalid, data_if.rdata}, {1'b1, 32'h12345678}); end
    checks++; if ({instr_if.gnt, data_if.gnt} !== 2'b10) begin failures++; $display("FAIL b2b_gnt got=%b exp=10", {instr_if.gnt, data_if.gnt}); end
    tick();
    clear_reqs();
    checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h7000}) begin failures++; $display("FAIL b2b_bus got=%h exp=%h", {mem_req_o, mem_addr_o}, {1'b1, 32'h7000}); end
    mem_rvalid_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    checks++; if ({instr_if.rvalid, data_if.rvalid} !== 2'b10) begin failures++; $display("FAIL b2b_done got=%b exp=10", {instr_if.rvalid, data_if.rvalid}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_error();
    test_timeout();
    test_reset_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
